// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default iteration count.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage <-> multiply/divide unit handshake: operands and launch in,
// busy/write pulse and HI/LO results out.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             cancel;
    logic             busy;
    logic             write;
    logic [WIDTH-1:0] hiOut;
    logic [WIDTH-1:0] loOut;

    modport master (
        output start, op, srcA, srcB, cancel,
        input  busy, write, hiOut, loOut
    );

    modport slave (
        input  start, op, srcA, srcB, cancel,
        output busy, write, hiOut, loOut
    );
endinterface

// File: rtl/mdu_iter_step.sv
// One multiply (add-or-pass, shift right) or restoring-divide (trial subtract,
// shift left) iteration on a shared WIDTH+1-bit adder. Divide path under MDU_DIV_EN.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
`ifdef MDU_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // The divider needs the adder's carry-out as its no-borrow flag.
`ifdef MDU_DIV_EN
    localparam int SW = WIDTH + 2;
`else
    localparam int SW = WIDTH + 1;
`endif

    logic [WIDTH:0] add_a;
    logic [WIDTH:0] add_b;
    logic           add_cin;
    logic [SW-1:0]  sum;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        add_a   = {1'b0, hi_i};
        add_b   = lo_i[0] ? {1'b0, opnd_i} : '0;
        add_cin = 1'b0;
`ifdef MDU_DIV_EN
        if (is_div_i) begin
            add_a   = {hi_i, lo_i[WIDTH-1]};
            add_b   = ~{1'b0, opnd_i};
            add_cin = 1'b1;
        end
`endif
    end

    assign sum = SW'(add_a) + SW'(add_b) + SW'(add_cin);

    always_comb begin
        hi_o = sum[WIDTH:1];
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (is_div_i) begin
            hi_o = sum[WIDTH+1] ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], sum[WIDTH+1]};
        end
`endif
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: FSM, iteration counter, operand and
// partial registers, sign fix. DIV/DIVU exist only when MDU_DIV_EN is defined.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d, out_lo_q, out_lo_d;
    logic             neg_res_q, neg_res_d;
`ifdef MDU_DIV_EN
    logic             is_div_q, is_div_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    logic             accept, commit, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo;

    always_comb begin
        a_neg = op_is_signed(bus.op) & bus.srcA[WIDTH-1];
        b_neg = op_is_signed(bus.op) & bus.srcB[WIDTH-1];
        a_mag = a_neg ? -bus.srcA : bus.srcA;
        b_mag = b_neg ? -bus.srcB : bus.srcB;
`ifdef MDU_DIV_EN
        accept = bus.start;
`else
        accept = bus.start & ~op_is_div(bus.op);
`endif
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
        .is_div_i (is_div_q),
`endif
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (bus.cancel) state_d = IDLE;
                     else if (cnt_q == LAST) state_d = FIX;
            FIX:     state_d = bus.cancel ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The result is presented during DONE so it is valid with the write pulse,
    // but only committed to the holding registers if DONE was not cancelled.
    always_comb begin
        commit    = (state_q == DONE) && !bus.cancel;
        bus.busy  = (state_q != IDLE);
        bus.write = commit;
        bus.hiOut = commit ? hi_q : out_hi_q;
        bus.loOut = commit ? lo_q : out_lo_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        out_hi_d  = out_hi_q;
        out_lo_d  = out_lo_q;
`ifdef MDU_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
`endif
        unique case (state_q)
            IDLE: if (accept) begin
                cnt_d     = '0;
                hi_d      = '0;
                lo_d      = b_mag;
                opnd_d    = a_mag;
                neg_res_d = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                is_div_d  = op_is_div(bus.op);
                neg_rem_d = a_neg;
                if (is_div_d) begin
                    lo_d      = a_mag;
                    opnd_d    = b_mag;
                    // A zero divisor keeps the raw all-ones quotient.
                    neg_res_d = (a_neg ^ b_neg) & (bus.srcB != '0);
                end
`endif
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
            end
            FIX: begin
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    if (neg_res_q) lo_d = -lo_q;
                    if (neg_rem_q) hi_d = -hi_q;
                end else if (neg_res_q) begin
                    {hi_d, lo_d} = -{hi_q, lo_q};
                end
`else
                if (neg_res_q) {hi_d, lo_d} = -{hi_q, lo_q};
`endif
            end
            DONE: if (commit) begin
                out_hi_d = hi_q;
                out_lo_d = lo_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            out_hi_q  <= '0;
            out_lo_q  <= '0;
`ifdef MDU_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            out_hi_q  <= out_hi_d;
            out_lo_q  <= out_lo_d;
`ifdef MDU_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level model plus per-cycle compare,
// directed vectors with hand-computed results; adapts to MDU_DIV_EN.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the ISA rules.
    function automatic void golden(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint    sp;
        logic [63:0] up;
        case (o)
            MDU_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = sp;
            end
            MDU_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            MDU_DIV: begin
                if (b == 0) begin
                    lo = '1; hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = '0;
                end else begin
                    lo = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 0) begin
                    lo = '1; hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    function automatic bit accepts(input logic [1:0] o);
`ifdef MDU_DIV_EN
        return 1'b1;
`else
        return !op_is_div(o);
`endif
    endfunction

    // Transaction model: cycles of busy left, pending and committed results.
    int          left;
    logic [W-1:0] p_hi, p_lo, m_hi, m_lo;

    always @(posedge clk or negedge rst) begin
        logic [W-1:0] g_hi, g_lo;
        if (!rst) begin
            left <= 0; m_hi <= '0; m_lo <= '0;
        end else if (left == 0) begin
            if (bus.start && accepts(bus.op)) begin
                golden(bus.op, bus.srcA, bus.srcB, g_hi, g_lo);
                p_hi <= g_hi; p_lo <= g_lo; left <= LAT;
            end
        end else if (bus.cancel) begin
            left <= 0;
        end else begin
            if (left == 1) begin
                m_hi <= p_hi; m_lo <= p_lo;
            end
            left <= left - 1;
        end
    end

    always @(negedge clk) begin
        logic exp_wr;
        if (rst) begin
            exp_wr = (left == 1) && !bus.cancel;
            check("busy",  64'(bus.busy),  64'(left != 0));
            check("write", 64'(bus.write), 64'(exp_wr));
            check("hiOut", 64'(bus.hiOut), 64'(exp_wr ? p_hi : m_hi));
            check("loOut", 64'(bus.loOut), 64'(exp_wr ? p_lo : m_lo));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit cwith, output int lat, output int bcnt,
                          output logic [W-1:0] hi_w, output logic [W-1:0] lo_w);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.srcA = a; bus.srcB = b; bus.cancel = cwith;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        lat = 0; bcnt = 0; hi_w = 'x; lo_w = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.write) begin
                lat = k; hi_w = bus.hiOut; lo_w = bus.loOut;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int           lat, bcnt, wcount;
        logic [W-1:0] hi_w, lo_w, last_hi, last_lo;
        bit           acc;

        vecs = '{
            '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
            '{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
            '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
            '{MDU_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001},
            '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
            '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
            '{MDU_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF},
            '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14},
            '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF},
            '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD},
            '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1},
            '{MDU_MULTU, 32'd5,         32'd6,         32'd0,         32'd30}
        };

        bus.start = 1'b0; bus.op = MDU_MULTU; bus.srcA = '0; bus.srcB = '0; bus.cancel = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  64'(bus.busy),  64'd0);
        check("rst_write", 64'(bus.write), 64'd0);
        check("rst_hi",    64'(bus.hiOut), 64'd0);
        check("rst_lo",    64'(bus.loOut), 64'd0);
        #2 rst = 1'b1;

        last_hi = '0; last_lo = '0;
        foreach (vecs[i]) begin
            acc = accepts(vecs[i].op);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcnt, hi_w, lo_w);
            if (acc) begin
                check("latency",     64'(lat),  64'(LAT));
                check("busy_cycles", 64'(bcnt), 64'(LAT));
                check("vec_hi",      64'(hi_w), 64'(vecs[i].hi));
                check("vec_lo",      64'(lo_w), 64'(vecs[i].lo));
                last_hi = vecs[i].hi; last_lo = vecs[i].lo;
            end else begin
                check("ignored_busy",  64'(bcnt), 64'd0);
                check("ignored_write", 64'(lat),  64'd0);
                check("ignored_hi",    64'(bus.hiOut), 64'(last_hi));
                check("ignored_lo",    64'(bus.loOut), 64'(last_lo));
            end
        end

        // Cancel in CALC cycle 10, with a stray start raised while busy.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.srcA = 32'h1234; bus.srcB = 32'h5678;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk); #1;
        bus.start = 1'b1; bus.srcA = 32'd9; bus.srcB = 32'd9;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk); #1; bus.cancel = 1'b1;
        @(posedge clk); #1; bus.cancel = 1'b0;
        check("calc_cancel_busy", 64'(bus.busy), 64'd0);
        wcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.write) wcount++;
        end
        check("calc_cancel_writes", 64'(wcount), 64'd0);
        check("calc_cancel_hi", 64'(bus.hiOut), 64'd0);
        check("calc_cancel_lo", 64'(bus.loOut), 64'd30);

        // Cancel during DONE suppresses the write and keeps the old result.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.srcA = 32'd3; bus.srcB = 32'd3;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (33) @(posedge clk); #1; bus.cancel = 1'b1;
        @(negedge clk);
        check("done_cancel_busy",  64'(bus.busy),  64'd1);
        check("done_cancel_write", 64'(bus.write), 64'd0);
        check("done_cancel_lo",    64'(bus.loOut), 64'd30);
        @(posedge clk); #1; bus.cancel = 1'b0;
        check("done_cancel_idle", 64'(bus.busy),  64'd0);
        check("done_cancel_hold", 64'(bus.loOut), 64'd30);

        // Cancel in IDLE alongside start: the start still launches.
        run_op(MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, lat, bcnt, hi_w, lo_w);
        check("idle_cancel_lat", 64'(lat),  64'(LAT));
        check("idle_cancel_hi",  64'(hi_w), 64'd1);
        check("idle_cancel_lo",  64'(lo_w), 64'd0);

        // Reset mid-CALC aborts immediately, no write afterwards.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.srcA = 32'd7; bus.srcB = 32'd7;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (11) @(posedge clk); #2 rst = 1'b0;
        #1;
        check("midrst_busy",  64'(bus.busy),  64'd0);
        check("midrst_write", 64'(bus.write), 64'd0);
        check("midrst_hi",    64'(bus.hiOut), 64'd0);
        check("midrst_lo",    64'(bus.loOut), 64'd0);
        repeat (2) @(posedge clk); #2 rst = 1'b1;
        wcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.write) wcount++;
        end
        check("midrst_writes", 64'(wcount), 64'd0);
        check("midrst_lo_hold", 64'(bus.loOut), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the 32-bit pipelined MIPS core. It accepts MULT, MULTU, DIV and DIVU operands from the EX stage. It computes the 64-bit product, or the quotient and remainder, over several cycles. When done it delivers the result to the HI/LO register file with a single one-cycle write pulse. The pipeline uses `busy` to stall MFHI/MFLO and to stall any further mult/div issue.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcA`  in  WIDTH  multiplicand or dividend (rs).
- `srcB`  in  WIDTH  multiplier or divisor (rt).
- `cancel`  in  1  abort the in-flight operation (pipeline flush).
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `write`  out  1  one-cycle pulse in DONE; drives the HI/LO write enable.
- `hiOut`  out  WIDTH  HI result: product upper half, or remainder.
- `loOut`  out  WIDTH  LO result: product lower half, or quotient.

## Operation
- States:
  - IDLE: `start` is accepted here. Operand magnitudes, result-sign flags and `op` are latched, and the iteration counter is cleared.
  - CALC: executes exactly `WIDTH` iterations.
  - FIX: applies sign correction.
  - DONE: asserts `write` for one cycle.
  - Transitions: IDLE→CALC on `start`; CALC→FIX when the counter reaches `WIDTH`-1; FIX→DONE; DONE→IDLE.
- Multiply:
  - Shift-add algorithm, one bit per CALC cycle, with a `WIDTH`+1-bit adder.
  - Signed ops multiply magnitudes. If the operand signs differ, FIX negates the full 2·`WIDTH`-bit product.
  - {hiOut,loOut} = exact product.
- Divide:
  - Restoring algorithm, one quotient bit per CALC cycle.
  - LO = quotient, HI = remainder.
  - Signed ops: quotient truncates toward zero, and the remainder takes the dividend's sign.
  - Divide by zero, any signedness: LO = all ones, HI = `srcA` unchanged. No sign fix is applied.
  - Signed overflow, -2^(WIDTH-1) / -1: LO = 0x80000000, HI = 0.
- `start` while `busy`=1 is ignored.
- `cancel` in CALC, FIX or DONE: return to IDLE next edge. In that case `write` stays 0 (DONE with `cancel` suppresses the pulse), and hiOut/loOut keep their previous values.
- `cancel` in IDLE has no effect, even if `start` is high in the same cycle; `start` is accepted.
- hiOut/loOut are registered. They update only in DONE and hold until the next completed operation.

## Timing
- `start` accepted at edge N:
  - CALC spans cycles N+1 .. N+`WIDTH`.
  - FIX is cycle N+`WIDTH`+1.
  - DONE is cycle N+`WIDTH`+2: `write`=1 and outputs valid.
  - State is IDLE at N+`WIDTH`+3.
- Latency: 34 cycles for `WIDTH`=32. `busy` is high for `WIDTH`+2 cycles.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE.
- Reset values: `busy`=0, `write`=0, `hiOut`=0, `loOut`=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately; no write follows deassertion.

## Configuration
- Macro: `MDU_DIV_EN`.
- Defined: full behaviour above.
- Undefined:
  - Divider datapath is removed.
  - DIV/DIVU `start` is ignored: `busy` stays 0, no `write`, outputs unchanged.
  - MULT/MULTU timing is unchanged.

## Structure
- Shared package `mdu_pkg` holds:
  - op encodings: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - state enum: IDLE, CALC, FIX, DONE;
  - `MDU_ITER` = `WIDTH`.
- Sub-module `mdu_iter_step`: combinational single-iteration datapath. It performs the add-or-pass step for multiply and the trial subtract/restore step for divide, on a `WIDTH`+1-bit adder. The top level contains the FSM, counter, operand/partial registers and sign fix.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `write` exactly 34 cycles after `start`; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for 34 cycles.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064.
- DIVU 100 / 7 → LO=14, HI=2.
- MULTU 5×6 completes (HI=0, LO=30). Then a second `start` is sent and `cancel` is pulsed in CALC cycle 10. Required: `busy`=0 next cycle, no `write`, outputs remain HI=0, LO=30. A further `start` raised while `busy` is ignored.
- Reset asserted mid-CALC → all outputs 0 immediately, no `write` after release.
